// File: rtl/rf_wb_arbiter.sv
// Register file writeback arbiter.
// Arbitrates the single register file write port between the ALU, LSU and
// MDU writeback channels. LSU/MDU results that have been waiting too long
// are served before the ALU. A busy scoreboard tracks destinations of
// outstanding long-latency ops so the issue stage can stall on hazards.
module rf_wb_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_wd,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_wd,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_wd,
  input  logic        sb_set,
  input  logic [4:0]  sb_rd,
  input  logic [4:0]  chk_r1,
  input  logic [4:0]  chk_r2,
  input  logic [4:0]  chk_wr,
  output logic        hazard,
  output logic        sb_overlap,
  output logic [31:0] busy_mask,
  output logic        rf_we,
  output logic [4:0]  rf_wr,
  output logic [31:0] rf_wd
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0]  lsu_cnt;
  logic [3:0]  mdu_cnt;
  logic        rr_mdu;     // 0: round-robin favours LSU, 1: favours MDU
  logic        wb_long;    // current output-stage write came from LSU/MDU
  logic [31:0] busy;
  logic [31:0] busy_nxt;
  logic        lsu_starve;
  logic        mdu_starve;
  logic        any_grant;
  logic        long_grant;
  logic [4:0]  sel_rd;
  logic [31:0] sel_wd;

  assign lsu_starve = lsu_valid && (lsu_cnt >= MAX_W);
  assign mdu_starve = mdu_valid && (mdu_cnt >= MAX_W);

  // Grant selection: starving long-latency units, then ALU, then round-robin.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    mdu_ready = 1'b0;
    if (lsu_starve && mdu_starve) begin
      if (rr_mdu) mdu_ready = 1'b1;
      else        lsu_ready = 1'b1;
    end else if (lsu_starve) begin
      lsu_ready = 1'b1;
    end else if (mdu_starve) begin
      mdu_ready = 1'b1;
    end else if (alu_valid) begin
      alu_ready = 1'b1;
    end else if (lsu_valid && mdu_valid) begin
      if (rr_mdu) mdu_ready = 1'b1;
      else        lsu_ready = 1'b1;
    end else if (lsu_valid) begin
      lsu_ready = 1'b1;
    end else if (mdu_valid) begin
      mdu_ready = 1'b1;
    end
  end

  assign long_grant = lsu_ready || mdu_ready;
  assign any_grant  = alu_ready || long_grant;

  // Mux the winning channel's destination and data into the output stage.
  always_comb begin
    sel_rd = alu_rd;
    sel_wd = alu_wd;
    if (lsu_ready) begin
      sel_rd = lsu_rd;
      sel_wd = lsu_wd;
    end else if (mdu_ready) begin
      sel_rd = mdu_rd;
      sel_wd = mdu_wd;
    end
  end

  // Starvation counters and round-robin pointer.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      lsu_cnt <= 4'd0;
      mdu_cnt <= 4'd0;
      rr_mdu  <= 1'b0;
    end else begin
      if (!lsu_valid || lsu_ready) lsu_cnt <= 4'd0;
      else if (lsu_cnt != 4'hF)    lsu_cnt <= lsu_cnt + 4'd1;
      if (!mdu_valid || mdu_ready) mdu_cnt <= 4'd0;
      else if (mdu_cnt != 4'hF)    mdu_cnt <= mdu_cnt + 4'd1;
      if (long_grant) rr_mdu <= lsu_ready;
    end
  end

  // Registered write port; x0 writes consume the slot but never enable.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      rf_we   <= 1'b0;
      rf_wr   <= 5'd0;
      rf_wd   <= 32'd0;
      wb_long <= 1'b0;
    end else if (any_grant) begin
      rf_we   <= (sel_rd != 5'd0);
      rf_wr   <= sel_rd;
      rf_wd   <= sel_wd;
      wb_long <= long_grant;
    end else begin
      rf_we   <= 1'b0;
    end
  end

  // Next scoreboard value: clear on long-latency write, then set (set wins).
  always_comb begin
    busy_nxt = busy;
    if (rf_we && wb_long) busy_nxt[rf_wr] = 1'b0;
    if (sb_set && (sb_rd != 5'd0)) busy_nxt[sb_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register and sticky overlap flag.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      busy       <= 32'd0;
      sb_overlap <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (sb_set && busy[sb_rd]) sb_overlap <= 1'b1;
    end
  end

  assign busy_mask = busy;
  assign hazard    = busy[chk_r1] | busy[chk_r2] | busy[chk_wr];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter (MAX_WAIT = 4).
module tb_rf_wb_arbiter;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0, mdu_valid = 1'b0;
  logic        alu_ready, lsu_ready, mdu_ready;
  logic [4:0]  alu_rd = '0, lsu_rd = '0, mdu_rd = '0;
  logic [31:0] alu_wd = '0, lsu_wd = '0, mdu_wd = '0;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_rd = '0, chk_r1 = '0, chk_r2 = '0, chk_wr = '0;
  logic        hazard, sb_overlap, rf_we;
  logic [31:0] busy_mask, rf_wd;
  logic [4:0]  rf_wr;

  int tests = 0;
  int fails = 0;

  rf_wb_arbiter #(.MAX_WAIT(4)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_wd(mdu_wd),
    .sb_set(sb_set), .sb_rd(sb_rd),
    .chk_r1(chk_r1), .chk_r2(chk_r2), .chk_wr(chk_wr),
    .hazard(hazard), .sb_overlap(sb_overlap), .busy_mask(busy_mask),
    .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
  endtask

  initial begin
    // Reset values
    cpu_rst = 1'b1;
    #2;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_wr", 32'(rf_wr), 32'd0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_overlap", 32'(sb_overlap), 32'd0);
    chk("rst_hazard", 32'(hazard), 32'd0);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;

    // ALU only
    @(negedge cpu_clk);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
    #1;
    chk("alu_ready", 32'(alu_ready), 32'd1);
    chk("alu_lsu_ready", 32'(lsu_ready), 32'd0);
    @(negedge cpu_clk);
    alu_valid = 1'b0;
    chk("alu_we", 32'(rf_we), 32'd1);
    chk("alu_wr", 32'(rf_wr), 32'd5);
    chk("alu_wd", rf_wd, 32'hDEADBEEF);
    @(negedge cpu_clk);
    chk("idle_we", 32'(rf_we), 32'd0);
    chk("idle_wr_hold", 32'(rf_wr), 32'd5);
    chk("idle_wd_hold", rf_wd, 32'hDEADBEEF);

    // x0 write from LSU
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_wd = 32'h0000_0123;
    #1;
    chk("x0_ready", 32'(lsu_ready), 32'd1);
    @(negedge cpu_clk);
    lsu_valid = 1'b0;
    chk("x0_we", 32'(rf_we), 32'd0);
    chk("x0_busy", busy_mask, 32'd0);

    // Round-robin from reset: LSU, MDU, LSU, MDU
    do_reset();
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_wd = 32'hA;
    mdu_valid = 1'b1; mdu_rd = 5'd11; mdu_wd = 32'hB;
    #1;
    chk("rr0_lsu", 32'(lsu_ready), 32'd1);
    chk("rr0_mdu", 32'(mdu_ready), 32'd0);
    @(negedge cpu_clk);
    chk("rr1_wr", 32'(rf_wr), 32'd10);
    chk("rr1_lsu", 32'(lsu_ready), 32'd0);
    chk("rr1_mdu", 32'(mdu_ready), 32'd1);
    @(negedge cpu_clk);
    chk("rr2_wr", 32'(rf_wr), 32'd11);
    chk("rr2_lsu", 32'(lsu_ready), 32'd1);
    @(negedge cpu_clk);
    chk("rr3_mdu", 32'(mdu_ready), 32'd1);
    chk("rr3_lsu", 32'(lsu_ready), 32'd0);
    @(negedge cpu_clk);
    lsu_valid = 1'b0; mdu_valid = 1'b0;

    // Starvation: LSU refused 4 cycles, granted on the 5th
    @(negedge cpu_clk);
    alu_valid = 1'b1; alu_rd = 5'd13; alu_wd = 32'hC0DE;
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_wd = 32'hF00D;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("stv%0d_alu", c), 32'(alu_ready), 32'd1);
      chk($sformatf("stv%0d_lsu", c), 32'(lsu_ready), 32'd0);
      @(negedge cpu_clk);
    end
    #1;
    chk("stv4_lsu", 32'(lsu_ready), 32'd1);
    chk("stv4_alu", 32'(alu_ready), 32'd0);
    @(negedge cpu_clk);
    chk("stv5_we_wr", 32'(rf_wr), 32'd12);
    chk("stv5_alu", 32'(alu_ready), 32'd1);
    chk("stv5_lsu", 32'(lsu_ready), 32'd0);
    alu_valid = 1'b0; lsu_valid = 1'b0;

    // Scoreboard
    @(negedge cpu_clk);
    sb_set = 1'b1; sb_rd = 5'd7;
    #1;
    chk("sb_pre_hazard", 32'(hazard), 32'd0);
    @(negedge cpu_clk);
    chk_r1 = 5'd7;
    #1;
    chk("sb_busy7", busy_mask, 32'h0000_0080);
    chk("sb_hazard_r1", 32'(hazard), 32'd1);
    chk("sb_no_overlap", 32'(sb_overlap), 32'd0);
    @(negedge cpu_clk);
    sb_set = 1'b0;
    chk("sb_overlap", 32'(sb_overlap), 32'd1);
    chk_r1 = 5'd0; chk_wr = 5'd7;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_wd = 32'h1;
    #1;
    chk("sb_hazard_wr", 32'(hazard), 32'd1);
    @(negedge cpu_clk);
    alu_valid = 1'b0;
    chk("sb_alu_we", 32'(rf_we), 32'd1);
    chk_r1 = 5'd7; chk_wr = 5'd0;
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_wd = 32'h77;
    sb_set = 1'b1; sb_rd = 5'd9;
    #1;
    chk("sb_mdu_ready", 32'(mdu_ready), 32'd1);
    @(negedge cpu_clk);
    sb_set = 1'b0;
    chk("sb_alu_keeps_busy", busy_mask, 32'h0000_0280);
    chk("sb_mdu_we", 32'(rf_we), 32'd1);
    chk("sb_mdu_wd", rf_wd, 32'h77);
    chk("sb_hazard_during_we", 32'(hazard), 32'd1);
    mdu_rd = 5'd9; mdu_wd = 32'h99;
    @(negedge cpu_clk);
    mdu_valid = 1'b0;
    chk("sb_hazard_after", 32'(hazard), 32'd0);
    chk("sb_busy_after", busy_mask, 32'h0000_0200);
    chk("sb_we9", 32'(rf_wr), 32'd9);
    sb_set = 1'b1; sb_rd = 5'd9;
    @(negedge cpu_clk);
    sb_set = 1'b0;
    chk("sb_set_wins", busy_mask, 32'h0000_0200);
    chk_r1 = 5'd0;

    // Async reset between accept and write
    @(negedge cpu_clk);
    sb_set = 1'b1; sb_rd = 5'd4;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_wd = 32'h66;
    lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_wd = 32'h88;
    #1;
    chk("ar_alu_ready", 32'(alu_ready), 32'd1);
    @(negedge cpu_clk);
    sb_set = 1'b0;
    chk("ar_busy4", busy_mask, 32'h0000_0210);
    @(negedge cpu_clk);
    chk("ar_we_before", 32'(rf_we), 32'd1);
    @(negedge cpu_clk);
    #2;
    cpu_rst = 1'b1;
    #1;
    chk("ar_we_now", 32'(rf_we), 32'd0);
    chk("ar_busy_now", busy_mask, 32'd0);
    chk("ar_overlap_now", 32'(sb_overlap), 32'd0);
    chk("ar_hazard_now", 32'(hazard), 32'd0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    chk("ar_no_write", 32'(rf_we), 32'd0);
    chk("ar_wr_zero", 32'(rf_wr), 32'd0);
    alu_valid = 1'b1; lsu_valid = 1'b1;
    #1;
    chk("ar_c0_alu", 32'(alu_ready), 32'd1);
    @(negedge cpu_clk);
    #1;
    chk("ar_c1_alu", 32'(alu_ready), 32'd1);
    chk("ar_c1_lsu", 32'(lsu_ready), 32'd0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge cpu_clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file and arbitrates it between three writeback sources: ALU (single-cycle), LSU (loads) and MDU (multiply/divide).
- Keeps a busy scoreboard of destinations with outstanding long-latency results, so the issue stage can stall on RAW/WAW hazards.
- Sits between the execute/memory units and the register file write port (rf_we / wR / wD).

Parameters:
- MAX_WAIT, 4: consecutive stalled cycles after which an LSU/MDU requester gets priority over ALU; legal range 1..15.

Ports:
- cpu_clk  in  1  clock
- cpu_rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_rd  in  5  ALU destination
- alu_wd  in  32  ALU result
- lsu_valid / lsu_ready / lsu_rd / lsu_wd  in / out / in / in  1 / 1 / 5 / 32  LSU writeback channel, same semantics
- mdu_valid / mdu_ready / mdu_rd / mdu_wd  in / out / in / in  1 / 1 / 5 / 32  MDU writeback channel, same semantics
- sb_set  in  1  issue stage dispatched a long-latency op (LSU or MDU)
- sb_rd  in  5  destination of that op
- chk_r1, chk_r2, chk_wr  in  5 each  source and destination registers of the instruction in issue
- hazard  out  1  issue must stall
- sb_overlap  out  1  sticky error: sb_set on an already-busy register
- busy_mask  out  32  scoreboard state, for debug
- rf_we  out  1  register file write enable
- rf_wr  out  5  register file write address
- rf_wd  out  32  register file write data

Behaviour:
- Handshake: a transfer occurs when X_valid && X_ready.
  - X_ready is combinational from the valid inputs, the starvation flags and the round-robin pointer.
  - At most one ready is high per cycle.
  - A requester holds valid, rd and wd stable until accepted.
- Arbitration order, evaluated each cycle:
  - Starving LSU/MDU first. When both starve, the round-robin pointer picks.
  - Otherwise ALU.
  - Otherwise LSU/MDU by round-robin pointer.
- Round-robin pointer: a 1-bit register, reset to LSU. On every LSU or MDU grant it flips to point at the other unit.
- Starvation counters: one per LSU/MDU, saturating 4-bit, reset to 0.
  - Increments each cycle the unit has valid && !ready.
  - Clears on grant or when valid is low.
  - The unit is starving while its count >= MAX_WAIT.
- Output stage is registered, with 1-cycle latency.
  - On the edge after an accept: rf_we = (rd != 0), rf_wr = rd, rf_wd = wd.
  - With no accept: rf_we = 0, and rf_wr / rf_wd hold their values.
  - Writes to x0 are accepted and consume the slot, but never assert rf_we.
- Scoreboard: a 32-bit busy register, reset to 0. Bit 0 is hardwired to 0.
  - Set: on sb_set with sb_rd != 0, busy[sb_rd] <= 1 at the clock edge.
  - Clear: busy[rf_wr] <= 0 at the edge ending a cycle with rf_we = 1 and the write sourced from LSU/MDU. A 1-bit source tag is registered with the output stage.
  - ALU writes never touch busy.
  - Set and clear to the same register on the same edge: set wins.
  - If sb_set hits a register that is already busy, set sb_overlap. It is cleared only by reset.
- hazard is combinational from the registered busy bits:
  - hazard = busy[chk_r1] | busy[chk_r2] | busy[chk_wr].
  - Index 0 always reads 0.
  - hazard drops in the cycle after the clearing write, when the register file already holds the new value.
- Reset values:
  - Outputs: rf_we = 0, rf_wr = 0, rf_wd = 0, busy_mask = 0, sb_overlap = 0, hazard = 0.
  - ready outputs follow their inputs combinationally.
- Reset asserted mid-operation: all state clears immediately and any in-flight output write is dropped. Requesters re-present after reset.

Test Plan:
- ALU only: alu_valid = 1, rd = 5, wd = 0xDEADBEEF -> alu_ready = 1 same cycle; next cycle rf_we = 1, rf_wr = 5, rf_wd = 0xDEADBEEF.
- x0 write: lsu_valid, rd = 0 -> lsu_ready = 1; next cycle rf_we = 0; busy_mask unchanged.
- Round-robin: LSU and MDU both continuously valid, ALU idle -> grants alternate LSU, MDU, LSU, MDU, starting with LSU after reset.
- Starvation, MAX_WAIT = 4: ALU and LSU continuously valid -> LSU is refused for 4 cycles and granted in the 5th; ALU is refused that cycle.
- Scoreboard: sb_set rd = 7, then chk_r1 = 7 -> hazard = 1. MDU writes rd = 7 -> hazard stays 1 during the rf_we cycle and is 0 the cycle after. A second sb_set rd = 7 before that write -> sb_overlap = 1.
- Async reset: assert cpu_rst between an accept and its write cycle -> rf_we = 0 immediately, busy_mask = 0, counters cleared, no write after release.
